// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
// Shares one byte-wide SPI master between two requesters. Each accepted
// transaction (1-5 bytes) runs under a single cs_n assertion with
// programmable setup/hold, and the collected RX bytes go back to the
// requester that was granted.
module spi_txn_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [39:0] req0_data,
  input  logic [2:0]  req0_len,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [39:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [39:0] req1_data,
  input  logic [2:0]  req1_len,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [39:0] req1_rdata,
  output logic        spi_start,
  output logic [39:0] spi_data_in,
  input  logic [7:0]  spi_data_out,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  output logic        cs_n
);

  // Setup/hold counter width; comfortably covers any sensible CS timing.
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic [39:0]   shreg_q, shreg_d;
  logic [39:0]   rx_q, rx_d;
  logic [2:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cs_n_q, cs_n_d;

  logic          ready_pulse;
  logic          done_pulse;
  logic          rdata_load;
  logic          pick;

  logic [1:0]    req_valid;
  logic [39:0]   req_data  [2];
  logic [2:0]    req_len   [2];
  logic [1:0]    req_ready;
  logic [1:0]    req_done;
  logic [39:0]   req_rdata [2];

  // Byte count clamp: 0 means one byte, anything above 5 means five.
  function automatic logic [2:0] eff_len(input logic [2:0] len);
    if (len == 3'd0) return 3'd1;
    if (len > 3'd5) return 3'd5;
    return len;
  endfunction

  assign req_valid   = {req1_valid, req0_valid};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;
  assign req_len[0]  = req0_len;
  assign req_len[1]  = req1_len;

  // With both requesting, the one that was not served last wins.
  assign pick = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

  // Per-requester handshake outputs and RX result registers.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic [39:0] rdata_q;

      assign req_ready[gi] = ready_pulse & (gnt_q == 1'(gi));
      assign req_done[gi]  = done_pulse & (gnt_q == 1'(gi));
      assign req_rdata[gi] = rdata_q;

      // Load the finished RX bytes for the granted requester only.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (rdata_load && (gnt_q == 1'(gi))) begin
          rdata_q <= rx_q;
        end
      end
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign req0_done  = req_done[0];
  assign req1_done  = req_done[1];
  assign req0_rdata = req_rdata[0];
  assign req1_rdata = req_rdata[1];
  assign cs_n       = cs_n_q;

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      shreg_q      <= '0;
      rx_q         <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      cs_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      shreg_q      <= shreg_d;
      rx_q         <= rx_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      cs_n_q       <= cs_n_d;
    end
  end

  // Next-state, datapath updates and handshake pulses.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    shreg_d      = shreg_q;
    rx_d         = rx_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    ready_pulse  = 1'b0;
    done_pulse   = 1'b0;
    rdata_load   = 1'b0;
    spi_start    = 1'b0;
    spi_data_in  = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          gnt_d        = pick;
          last_grant_d = pick;
          shreg_d      = req_data[pick];
          rem_d        = eff_len(req_len[pick]);
          rx_d         = '0;
          cnt_d        = '0;
          state_d      = S_SETUP;
        end
      end

      S_SETUP: begin
        // Accept pulse coincides with the first cycle of cs_n low.
        ready_pulse = (cnt_q == '0);
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_START: begin
        // Gated by rst so a reset never launches a byte on its way out.
        if (!spi_busy && !rst) begin
          spi_start   = 1'b1;
          spi_data_in = {32'h0, shreg_q[39:32]};
          shreg_d     = {shreg_q[31:0], 8'h00};
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (spi_new_data) begin
          rx_d  = {rx_q[31:0], spi_data_out};
          rem_d = rem_q - 3'd1;
          cnt_d = '0;
          if (rem_q == 3'd1) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_START;
          end
        end
      end

      S_HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          cnt_d      = '0;
          rdata_load = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        done_pulse = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // cs_n is registered from the next state so it never glitches.
    cs_n_d = !((state_d == S_SETUP) || (state_d == S_START) ||
               (state_d == S_WAIT)  || (state_d == S_HOLD));
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one byte-wide SPI master between two requesters and sequences multi-byte transactions (1-5 bytes) under one chip-select assertion.
- Arbitrates round-robin, generates cs_n with programmable setup/hold, and feeds bytes one at a time over the master's start/busy/new_data handshake.
- Collects received bytes and returns them to the granted requester with a done pulse.

Parameters:
- CS_SETUP, 2, cycles cs_n is low before the first byte's spi_start (min 1).
- CS_HOLD, 2, cycles cs_n stays low after the last byte's spi_new_data (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a transaction; held until req0_ready
- req0_data  in  40  TX bytes, left-justified; first byte is [39:32]
- req0_len  in  3  byte count; 0 is treated as 1, 6..7 as 5
- req0_ready  out  1  one-cycle accept pulse
- req0_done  out  1  one-cycle completion pulse
- req0_rdata  out  40  RX bytes, right-justified; valid when req0_done
- req1_valid, req1_data, req1_len, req1_ready, req1_done, req1_rdata  same as requester 0
- spi_start  out  1  start pulse to the SPI master
- spi_data_in  out  40  {32'b0, tx_byte}; the master sends bits [7:0] MSB-first
- spi_data_out  in  8  byte received by the master
- spi_busy  in  1  master busy
- spi_new_data  in  1  master byte-complete pulse
- cs_n  out  1  active-low chip select

Behaviour:
Reset values (all outputs):
- cs_n=1; spi_start=0; spi_data_in=0.
- All ready/done pulses 0; rdata outputs 0.
- Round-robin pointer last_grant=1, so req0 wins the first contest.
- rst mid-transaction aborts immediately: cs_n=1 next cycle, no done, latched transaction dropped.

States: IDLE, SETUP, START, WAIT, HOLD, DONE.

IDLE:
- If exactly one valid is high, grant it.
- If both are high, grant the requester that is not last_grant.
- On grant: latch data, effective length and grant id; update last_grant; go to SETUP.
- In the next cycle (first SETUP cycle): cs_n=0 and reqN_ready=1 for exactly that one cycle.

SETUP:
- Lasts exactly CS_SETUP cycles, then go to START.

START:
- When spi_busy=0: assert spi_start for one cycle with spi_data_in={32'b0, shreg[39:32]}; shift shreg left by 8; go to WAIT.
- When spi_busy=1: spi_start stays 0 and the block waits in START.

WAIT:
- On spi_new_data: rx={rx[31:0], spi_data_out}; decrement remaining.
- If remaining was 1, go to HOLD; otherwise go to START.
- spi_start is never asserted in WAIT.

HOLD:
- cs_n stays low for exactly CS_HOLD cycles, then go to DONE.

DONE:
- cs_n=1; reqN_rdata<=rx for the granted requester only; reqN_done pulses for 1 cycle coincident with the updated rdata; go to IDLE.
- The other requester's rdata is unchanged.

Timing and boundary rules:
- cs_n is high for at least 2 cycles between transactions (DONE + IDLE). No grant decision is made in DONE.
- Unaccepted requests wait; valid deasserted before ready is a legal withdrawal.
- Valid changes while busy are ignored until IDLE.
- rx is cleared at grant, so unused upper rdata bytes are 0 (len=2 yields rdata[39:16]=0).
- Per-byte cycle count depends on the master's CLK_DIV; the arbiter relies only on the handshake.

Test Plan:
- req0 valid, data=0xA5_00000000, len=1, loopback master returns 0x3C -> one spi_start with spi_data_in=0xA5; cs_n low from ready through CS_HOLD after new_data; req0_done with req0_rdata=0x0000_00003C.
- req0 and req1 valid in the same cycle after reset -> req0 granted first, then req1; both raised again -> req0 (last_grant=1); req1 alone then both -> alternation holds.
- len=5, data=0x11_22_33_44_55, master echoes TX -> bytes 0x11..0x55 issued in order, exactly 5 spi_start pulses under one cs_n low, rdata=0x1122334455.
- len=0 -> exactly 1 byte sent; len=7 -> exactly 5 bytes sent.
- spi_busy forced high for 10 cycles in START -> spi_start withheld, then a single pulse once busy drops.
- rst asserted during the 3rd byte of a len=5 transfer -> cs_n=1 next cycle, no done pulse, no spi_start; a fresh req1 afterwards completes normally.
